// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define TX_PARITY_EN to compile in the parity bit between the last data bit and the stop bit.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  output logic             SOUT,
  output logic             BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             sout_q;
  logic             bit_done;
  logic             accept;
`ifdef TX_PARITY_EN
  logic             par_q;
`endif

  assign bit_done = (cnt == CNT_LAST);
  // READY also opens in the final stop cycle so frames can run back to back.
  assign READY    = (state == IDLE) || ((state == STOP) && bit_done);
  assign accept   = VALID && READY;
  assign BUSY     = (state != IDLE);
  assign SOUT     = sout_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      // NOTE: the shift register is plain flops, not a RAM, so resetting it is cheap and keeps it deterministic.
      shreg   <= '0;
      sout_q  <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= START;
            cnt    <= '0;
            shreg  <= DIN;
            sout_q <= 1'b0;
`ifdef TX_PARITY_EN
            par_q  <= ^DIN;
`endif
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            sout_q  <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
              state  <= PARITY;
              sout_q <= par_q;
`else
              state  <= STOP;
              sout_q <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              sout_q  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            cnt    <= '0;
            sout_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (accept) begin
              state  <= START;
              shreg  <= DIN;
              sout_q <= 1'b0;
`ifdef TX_PARITY_EN
              par_q  <= ^DIN;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          sout_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Frame expectations follow TX_PARITY_EN when the bench is built with it.
module tb_serial_tx;

`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, sout_a, busy_a;
  logic       ready_b, sout_b, busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .CLK(clk), .RST(rst), .DIN(din_a), .VALID(valid_a),
    .READY(ready_a), .SOUT(sout_a), .BUSY(busy_a)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
    .CLK(clk), .RST(rst), .DIN(din_b), .VALID(valid_b),
    .READY(ready_b), .SOUT(sout_b), .BUSY(busy_b)
  );

  typedef struct {
    logic [7:0] din;
    logic       par;      // hand-computed even parity of din
    bit         disturb;  // raise VALID with 0x3C and alter DIN mid-frame
    bit         b2b;      // keep VALID high and chain the next entry's word
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NB == 11 && k == 9) return p;
    return 1'b1;
  endfunction

  // Called just after the accept edge; checks every cycle of the frame at the falling edge.
  task automatic run_frame(input bit use_b, input int cpb, input logic [7:0] d, input logic p,
                           input bit disturb, input bit chain, input logic [7:0] next_d);
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        check($sformatf("sout bit%0d cyc%0d", k, c), use_b ? sout_b : sout_a, exp_bit(d, p, k));
        check($sformatf("busy bit%0d cyc%0d", k, c), use_b ? busy_b : busy_a, 1);
        check($sformatf("ready bit%0d cyc%0d", k, c), use_b ? ready_b : ready_a,
              (k == NB - 1 && c == cpb - 1) ? 1 : 0);
        if (disturb && k == 2 && c == 0) begin valid_a = 1'b1; din_a = 8'h3C; end
        if (disturb && k == 5 && c == 0) begin valid_a = 1'b0; din_a = 8'hFF; end
        if (chain && k == NB - 1 && c == cpb - 1) din_a = next_d;
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("idle busy", use_b ? busy_b : busy_a, 0);
      check("idle sout", use_b ? sout_b : sout_a, 1);
      check("idle ready", use_b ? ready_b : ready_a, 1);
    end
  endtask

  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (!ready_a && n < 200) begin @(negedge clk); n++; end
    check("ready_a within budget", (n < 200) ? 1 : 0, 1);
  endtask

  vec_t vecs[5];
  time  t_prev;

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{din: 8'hA5, par: 1'b0, disturb: 1'b0, b2b: 1'b0};
    vecs[1] = '{din: 8'h07, par: 1'b1, disturb: 1'b0, b2b: 1'b0};
    vecs[2] = '{din: 8'h5A, par: 1'b0, disturb: 1'b1, b2b: 1'b0};
    vecs[3] = '{din: 8'h00, par: 1'b0, disturb: 1'b0, b2b: 1'b1};
    vecs[4] = '{din: 8'hFF, par: 1'b0, disturb: 1'b0, b2b: 1'b0};

    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; din_a = 8'h00; din_b = 8'h00;
    #1;
    check("reset sout", sout_a, 1);
    check("reset ready", ready_a, 1);
    check("reset busy", busy_a, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven frames on the 4-clock instance.
    begin
      bit chained = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (!chained) begin
          wait_ready_a();
          din_a = vecs[i].din; valid_a = 1'b1;
          @(posedge clk); #1;
          if (!vecs[i].b2b) valid_a = 1'b0;
        end else begin
          check("b2b start spacing", 32'($time - t_prev), 32'(NB * 4 * 10));
        end
        t_prev = $time;
        run_frame(1'b0, 4, vecs[i].din, vecs[i].par, vecs[i].disturb, vecs[i].b2b,
                  (i < 4) ? vecs[i+1].din : 8'h00);
        if (vecs[i].b2b) begin
          @(posedge clk); #1;
          if (!vecs[i+1].b2b) valid_a = 1'b0;
        end
        chained = vecs[i].b2b;
      end
    end

    // Reset during the start bit aborts the frame without a clock edge.
    wait_ready_a();
    din_a = 8'hA5; valid_a = 1'b1;
    @(posedge clk); #1; valid_a = 1'b0;
    @(negedge clk);
    check("pre-reset sout low", sout_a, 0);
    #2 rst = 1'b1;
    #1;
    check("async reset sout", sout_a, 1);
    check("async reset ready", ready_a, 1);
    check("async reset busy", busy_a, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("post-reset idle sout c%0d", c), sout_a, 1);
      check($sformatf("post-reset idle busy c%0d", c), busy_a, 0);
    end

    // One clock per bit: 0x81 on the fast instance.
    @(negedge clk);
    check("fast ready idle", ready_b, 1);
    din_b = 8'h81; valid_b = 1'b1;
    @(posedge clk); #1; valid_b = 1'b0;
    run_frame(1'b1, 1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parameterised asynchronous-style serial transmitter built on the team's edge-triggered flip-flop cell. It accepts a parallel word through a valid/ready handshake and drives it onto a single serial line as a framed bit stream: start bit, data LSB first, optional parity, stop bit. It is the sending end of the team's single-wire serial link and pairs with the matching serial receiver at the far end of the line.

## Interface
- WIDTH, 8: data word width in bits; legal range 1 to 16.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range 1 to 256.

- CLK  input  1  sole clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- DIN  input  WIDTH  parallel word to send; sampled only on the accept edge.
- VALID  input  1  DIN holds a word to send.
- READY  output  1  transmitter can accept a word this cycle.
- SOUT  output  1  serial line; idle level 1; registered output.
- BUSY  output  1  a frame is in progress (any state other than IDLE).

## Operation
- Accept: a word is taken on a rising CLK edge where VALID=1 and READY=1. DIN is copied into an internal shift register on that edge; later DIN changes have no effect on the frame in flight.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: SOUT=1, READY=1, BUSY=0. Accept -> START.
- START: SOUT=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: WIDTH bits, LSB first, each held CLKS_PER_BIT cycles; a bit index counter counts 0 to WIDTH-1; after the last bit -> PARITY if compiled in, otherwise STOP.
- PARITY: SOUT = XOR of all WIDTH accepted data bits (even parity) for CLKS_PER_BIT cycles -> STOP.
- STOP: SOUT=1 for CLKS_PER_BIT cycles, then -> IDLE, or -> START directly if an accept occurs on the final STOP edge.
- READY = 1 in IDLE, and also in the last cycle of STOP (bit-period counter = CLKS_PER_BIT-1). READY=0 everywhere else. This allows back-to-back frames with no idle gap.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide (minimum 1). It resets to 0 at every bit boundary and wraps at CLKS_PER_BIT-1, never beyond.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle. READY is high in the single STOP cycle.
- VALID while READY=0 is ignored. The word is not queued, and VALID may drop without effect.

## Timing
- Reset values (asynchronous, applied immediately while RST=1): state IDLE, SOUT=1, READY=1, BUSY=0, counters 0, shift register 0.
- RST asserted mid-frame aborts the frame: SOUT goes to 1 without waiting for a clock edge. No partial-frame completion after RST deasserts.
- Latency: SOUT falls (start bit) on the same edge that accepts the word. BUSY rises on that edge.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT cycles with parity.
- Back-to-back: with VALID held high, consecutive start bits are exactly one frame length apart. SOUT is never 1 for more than CLKS_PER_BIT cycles between frames.
- BUSY falls on the edge that leaves STOP to IDLE. It stays 1 across back-to-back frames.

## Configuration
- TX_PARITY_EN defined: the PARITY state exists and each frame carries one even-parity bit between the last data bit and the stop bit.
- TX_PARITY_EN undefined: there is no PARITY state, and DATA goes directly to STOP.

## Test plan
- Reset: hold RST=1 mid-frame, then release. Required: SOUT=1, READY=1 and BUSY=0 immediately (before any CLK edge), and the line idles afterwards.
- Single frame: WIDTH=8, CLKS_PER_BIT=4, send 0xA5 without parity. Required: SOUT shows 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles (40 cycles total), and BUSY falls after cycle 40.
- Parity: with TX_PARITY_EN, send 0xA5 and then 0x07. Required: parity bit 0 for 0xA5 and 1 for 0x07, with 44-cycle frames.
- Back-to-back: VALID held high with 0x00 then 0xFF. Required: the second start bit begins exactly 40 cycles after the first, with exactly 4 idle-high stop cycles between frames, and READY pulses for one cycle.
- Ignored request and DIN stability: assert VALID with 0x3C during the DATA state, and change DIN mid-frame. Required: no accept occurs and the original word is transmitted unchanged.
- Minimum period: CLKS_PER_BIT=1, send 0x81. Required: a 10-cycle frame of 0,1,0,0,0,0,0,0,1,1, with READY high in the stop cycle.
